dm_mem_bus_adapter: RTL and testbench

//  - Upstream bus front-end for the debug-memory read/write stage.
//  - Accepts hart-side valid/ready load/store requests and range/alignment-checks them.
//  - Issues single-cycle req/we/addr/wdata/be strobes to the debug-memory stage and captures its 64-bit rdata.
//  - Returns a 32-bit response on a valid/ready channel. One transaction in flight; fully registered toward the DM.

---
 rtl/dm_mem_bus_adapter.sv | 164 ++++++++++++++++
 tb/tb_dm_mem_bus_adapter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_mem_bus_adapter.sv
// dm_mem_bus_adapter
//   Hart-side front-end for the debug-memory read/write stage. Takes one valid/ready
//   load/store at a time, checks it against the DM window and for word alignment, issues
//   a single-cycle registered access to the DM stage, and returns a 32-bit response.
//
//   Ports
//     clk_i, rst_i          clock, asynchronous active-high reset
//     hart_req_*            request channel (valid/ready, we, addr, wdata, be)
//     hart_rsp_*            response channel (valid/ready, rdata, err)
//     req_o/we_o/addr_o/
//     wdata_o/be_o          DM access strobe and fields (all registered)
//     rdata_i               DM 64-bit read data, valid the cycle after req_o
//
//   Build option
//     DM_BUS_ERR_EN  defined: out-of-range/misaligned accesses respond with err=1.
//                    undefined: err tied low; such reads return 0, writes are dropped.
//
//   Timing: accept in cycle N -> req_o in N+1 -> rsp_valid in N+3.
//           Rejected access -> rsp_valid in N+1, no req_o.

module dm_mem_bus_adapter #(
   parameter int unsigned AddrWidth               = 32,
   parameter int unsigned DbgAddressBits          = 12,
   parameter logic [AddrWidth-1:0] DmBaseAddr     = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      hart_req_valid_i,
   output logic                      hart_req_ready_o,
   input  logic                      hart_we_i,
   input  logic [AddrWidth-1:0]      hart_addr_i,
   input  logic [31:0]               hart_wdata_i,
   input  logic [3:0]                hart_be_i,
   output logic                      hart_rsp_valid_o,
   input  logic                      hart_rsp_ready_i,
   output logic [31:0]               hart_rsp_rdata_o,
   output logic                      hart_rsp_err_o,
   output logic                      req_o,
   output logic                      we_o,
   output logic [DbgAddressBits-1:0] addr_o,
   output logic [31:0]               wdata_o,
   output logic [3:0]                be_o,
   input  logic [63:0]               rdata_i
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

   state_e                    state_q, state_d;
   logic                      req_q, req_d;
   logic                      we_q, we_d;
   logic [DbgAddressBits-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [3:0]                be_q, be_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [31:0]               rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_err_q, rsp_err_d;

   logic hit;
   logic aligned;
   logic reject_err;

   // Upper-bit compare only, so every offset inside the window (including the last word)
   // hits and base + window misses.
   assign hit     = hart_addr_i[AddrWidth-1:DbgAddressBits] ==
                    DmBaseAddr[AddrWidth-1:DbgAddressBits];
   assign aligned = hart_addr_i[1:0] == 2'b00;

`ifdef DM_BUS_ERR_EN
   assign reject_err = 1'b1;
`else
   assign reject_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      req_d       = 1'b0;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         StIdle: begin
            // Ready is high whenever idle; reset is handled by the flops themselves.
            if (hart_req_valid_i) begin
               if (hit && aligned) begin
                  state_d = StIssue;
                  req_d   = 1'b1;
                  we_d    = hart_we_i;
                  addr_d  = hart_addr_i[DbgAddressBits-1:0];
                  wdata_d = hart_wdata_i;
                  be_d    = hart_we_i ? hart_be_i : 4'hF;
               end else begin
                  // Rejected: answer directly, DM stage untouched.
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_err_d   = reject_err;
               end
            end
         end
         StIssue: begin
            state_d = StCapture;
         end
         StCapture: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            if (we_q) begin
               rsp_rdata_d = '0;
            end else begin
               rsp_rdata_d = addr_q[2] ? rdata_i[63:32] : rdata_i[31:0];
            end
         end
         StResp: begin
            if (hart_rsp_ready_i) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Ready is gated by rst_i so it reads low for the whole reset pulse.
   assign hart_req_ready_o = (state_q == StIdle) && !rst_i;
   assign hart_rsp_valid_o = rsp_valid_q;
   assign hart_rsp_rdata_o = rsp_rdata_q;
   assign hart_rsp_err_o   = rsp_err_q;
   assign req_o            = req_q;
   assign we_o             = we_q;
   assign addr_o           = addr_q;
   assign wdata_o          = wdata_q;
   assign be_o             = be_q;

endmodule

// File: tb/tb_dm_mem_bus_adapter.sv
// Scoreboard bench for dm_mem_bus_adapter: stimulus pushes expected DM accesses and
// responses into queues; a monitor pops and compares when req_o / hart_rsp_valid_o appear.

module tb_dm_mem_bus_adapter;

   localparam logic [31:0] Base = 32'h0004_0000;
`ifdef DM_BUS_ERR_EN
   localparam logic ErrVal = 1'b1;
`else
   localparam logic ErrVal = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        dm_req;
   logic        dm_we;
   logic [11:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic [63:0] dm_rdata = '0;
   logic [63:0] dm_word = '0;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int hs_cyc = -1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          due;
   } dm_t;

   rsp_t rsp_q[$];
   dm_t  dm_q[$];

   dm_mem_bus_adapter #(
      .AddrWidth      (32),
      .DbgAddressBits (12),
      .DmBaseAddr     (Base)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .hart_req_valid_i (req_valid),
      .hart_req_ready_o (req_ready),
      .hart_we_i        (req_we),
      .hart_addr_i      (req_addr),
      .hart_wdata_i     (req_wdata),
      .hart_be_i        (req_be),
      .hart_rsp_valid_o (rsp_valid),
      .hart_rsp_ready_i (rsp_ready),
      .hart_rsp_rdata_o (rsp_rdata),
      .hart_rsp_err_o   (rsp_err),
      .req_o            (dm_req),
      .we_o             (dm_we),
      .addr_o           (dm_addr),
      .wdata_o          (dm_wdata),
      .be_o             (dm_be),
      .rdata_i          (dm_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // DM model: data valid only the cycle after req_o, filler otherwise.
   always @(posedge clk) dm_rdata <= dm_req ? dm_word : 64'h5A5A_C3C3_0F0F_9696;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: samples 1 time unit after the falling edge.
   logic        prev_req = 1'b0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_rdata = '0;
   logic        prev_err = 1'b0;

   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         prev_req   = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (dm_req) begin
            dm_t e;
            chk("req_single_cycle", {63'd0, prev_req}, 64'd0);
            if (dm_q.size() == 0) begin
               chk("unexpected_req", 64'd1, 64'd0);
            end else begin
               e = dm_q.pop_front();
               chk("dm_cycle", 64'(cyc), 64'(e.due));
               chk("dm_we", {63'd0, dm_we}, {63'd0, e.we});
               chk("dm_addr", {52'd0, dm_addr}, {52'd0, e.addr});
               chk("dm_be", {60'd0, dm_be}, {60'd0, e.be});
               if (e.we) chk("dm_wdata", {32'd0, dm_wdata}, {32'd0, e.wdata});
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               rsp_t r;
               r = rsp_q[0];
               if (!prev_valid) begin
                  chk("rsp_latency", 64'(cyc), 64'(r.due));
               end else begin
                  chk("rsp_rdata_stable", {32'd0, rsp_rdata}, {32'd0, prev_rdata});
                  chk("rsp_err_stable", {63'd0, rsp_err}, {63'd0, prev_err});
               end
               chk("ready_low_in_resp", {63'd0, req_ready}, 64'd0);
               if (rsp_ready) begin
                  chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, r.rdata});
                  chk("rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
                  void'(rsp_q.pop_front());
                  hs_cyc = cyc;
               end
            end
         end
         prev_req   = dm_req;
         prev_valid = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
         prev_err   = rsp_err;
      end
   end

   // Present one request, wait (bounded) for acceptance and queue the expectations.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic hit, input logic [31:0] exp_rdata,
                         output int acc);
      rsp_t r;
      dm_t  d;
      int   n;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 64'd1, 64'd0);
         acc = -1;
         req_valid = 1'b0;
      end else begin
         acc     = cyc;
         r.rdata = (hit && !we) ? exp_rdata : 32'd0;
         r.err   = hit ? 1'b0 : ErrVal;
         r.due   = acc + (hit ? 3 : 1);
         rsp_q.push_back(r);
         if (hit) begin
            d.we    = we;
            d.addr  = addr[11:0];
            d.wdata = wdata;
            d.be    = we ? be : 4'hF;
            d.due   = acc + 1;
            dm_q.push_back(d);
         end
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || dm_q.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
      chk("drain_dm_q", 64'(dm_q.size()), 64'd0);
   endtask

   initial begin
      int acc;
      int acc_b;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_req", {63'd0, dm_req}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_outputs", {dm_we, dm_addr, dm_be, rsp_err}, 64'd0);
      chk("rst_data", {rsp_rdata, dm_wdata}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {63'd0, req_ready}, 64'd1);

      // Reads, word select by addr[2]
      dm_word = 64'hAAAA_BBBB_1111_2222;
      do_req(1'b0, Base + 32'h008, 32'd0, 4'h0, 1'b1, 32'h1111_2222, acc);
      drain();
      do_req(1'b0, Base + 32'h00C, 32'd0, 4'h0, 1'b1, 32'hAAAA_BBBB, acc);
      drain();
      // Writes, including be=0
      do_req(1'b1, Base + 32'h100, 32'hDEAD_BEEF, 4'h3, 1'b1, 32'd0, acc);
      drain();
      do_req(1'b1, Base + 32'h010, 32'h1234_5678, 4'h0, 1'b1, 32'd0, acc);
      drain();
      // Window edges and rejects
      dm_word = 64'h0123_4567_89AB_CDEF;
      do_req(1'b0, Base + 32'hFFC, 32'd0, 4'h0, 1'b1, 32'h0123_4567, acc);
      drain();
      do_req(1'b0, Base + 32'h1000, 32'd0, 4'h0, 1'b0, 32'd0, acc);
      drain();
      do_req(1'b0, Base + 32'h002, 32'd0, 4'h0, 1'b0, 32'd0, acc);
      drain();
      do_req(1'b0, 32'h0000_0008, 32'd0, 4'h0, 1'b0, 32'd0, acc);
      drain();
      do_req(1'b1, Base + 32'h101, 32'hCAFE_F00D, 4'hF, 1'b0, 32'd0, acc);
      drain();

      // Response backpressure with a second request waiting
      dm_word   = 64'h3333_3333_4444_4444;
      rsp_ready = 1'b0;
      do_req(1'b0, Base + 32'h020, 32'd0, 4'h0, 1'b1, 32'h4444_4444, acc);
      fork
         begin
            int n;
            n = 0;
            while (!rsp_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            repeat (5) @(negedge clk);
            rsp_ready = 1'b1;
         end
         begin
            do_req(1'b0, Base + 32'h024, 32'd0, 4'h0, 1'b1, 32'h3333_3333, acc_b);
         end
      join
      chk("b2b_accept_cycle", 64'(acc_b), 64'(hs_cyc + 1));
      drain();

      // Reset during ISSUE
      dm_word = 64'h7777_7777_8888_8888;
      do_req(1'b0, Base + 32'h030, 32'd0, 4'h0, 1'b1, 32'h8888_8888, acc);
      chk("issue_before_reset", {63'd0, dm_req}, 64'd1);
      rst = 1'b1;
      #1;
      chk("reset_drops_req", {63'd0, dm_req}, 64'd0);
      chk("reset_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("reset_ready_low", {63'd0, req_ready}, 64'd0);
      rsp_q.delete();
      dm_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      do_req(1'b0, Base + 32'h034, 32'd0, 4'h0, 1'b1, 32'h7777_7777, acc);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
